// File: rtl/evac_dispatcher.sv
// rtl/evac_dispatcher.sv - pops evacuation requests and assigns them to free rescue teams with mission timers
// Optional completed-mission counter enabled by defining EVAC_MISSION_STATS_EN.
module evac_dispatcher #(
  parameter int NUM_TEAMS = 4,
  parameter int TEAM_W    = 2,
  parameter int T_BASE    = 16,
  parameter int TIMER_W   = 12
) (
  input  logic                 Main_Clock,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic                 Empty,
  input  logic [7:0]           Queue_Zone,
  input  logic [1:0]           Queue_Priority,
  input  logic                 Recall,
  output logic                 Serve,
  output logic                 Dispatch_Valid,
  output logic [7:0]           Dispatch_Zone,
  output logic [TEAM_W-1:0]    Dispatch_Team,
  output logic [NUM_TEAMS-1:0] Team_Busy,
  output logic [7:0]           Missions_Done
);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  localparam logic [TIMER_W-1:0] T_BASE_W = TIMER_W'(T_BASE);

  state_t             state, state_next;
  logic               start;
  logic               any_free;
  logic [TEAM_W-1:0]  sel;
  logic [1:0]         prio_q;
  logic [TIMER_W-1:0] timer [NUM_TEAMS];

  // Descending scan leaves the lowest-index free team in sel.
  always_comb begin
    sel      = '0;
    any_free = 1'b0;
    for (int i = NUM_TEAMS - 1; i >= 0; i--) begin
      if (!Team_Busy[i]) begin
        sel      = TEAM_W'(i);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (Enable && !Empty && any_free && !Recall) begin
          start      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Main_Clock) begin
    if (Reset) begin
      state          <= IDLE;
      Serve          <= 1'b0;
      Dispatch_Valid <= 1'b0;
      Dispatch_Zone  <= '0;
      Dispatch_Team  <= '0;
      prio_q         <= '0;
    end else begin
      state          <= state_next;
      Serve          <= start;
      Dispatch_Valid <= start;
      if (start) begin
        Dispatch_Zone <= Queue_Zone;
        Dispatch_Team <= sel;
        prio_q        <= Queue_Priority;
      end
    end
  end

  // Recall overrides the assignment made at the end of ISSUE.
  always_ff @(posedge Main_Clock) begin
    for (int i = 0; i < NUM_TEAMS; i++) begin
      if (Reset || Recall) begin
        Team_Busy[i] <= 1'b0;
        timer[i]     <= '0;
      end else if (state == ISSUE && Dispatch_Team == TEAM_W'(i)) begin
        Team_Busy[i] <= 1'b1;
        timer[i]     <= T_BASE_W << (2'd3 - prio_q);
      end else if (Team_Busy[i]) begin
        if (timer[i] == TIMER_W'(1)) begin
          Team_Busy[i] <= 1'b0;
          timer[i]     <= '0;
        end else begin
          timer[i] <= timer[i] - TIMER_W'(1);
        end
      end
    end
  end

`ifdef EVAC_MISSION_STATS_EN
  logic [NUM_TEAMS-1:0] expire;
  logic [3:0]           n_exp;
  logic [8:0]           done_sum;

  always_comb begin
    n_exp = '0;
    for (int i = 0; i < NUM_TEAMS; i++) begin
      expire[i] = Team_Busy[i] && (timer[i] == TIMER_W'(1)) && !Recall;
      n_exp     = n_exp + 4'(expire[i]);
    end
    done_sum = {1'b0, Missions_Done} + 9'(n_exp);
  end

  always_ff @(posedge Main_Clock) begin
    if (Reset) begin
      Missions_Done <= '0;
    end else if (done_sum > 9'd255) begin
      Missions_Done <= 8'd255;
    end else begin
      Missions_Done <= done_sum[7:0];
    end
  end
`else
  assign Missions_Done = 8'd0;
`endif

endmodule
